// File: rtl/alu_seq.sv
// alu_seq: registered ALU with start/done handshake, status flags and iterative shift-add multiply
//   clk    - system clock, rising edge
//   rst    - asynchronous active-low reset
//   start  - operation request, accepted only while busy=0
//   sl     - opcode: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 OR, 101 XOR, 110 MUL, 111 illegal
//   Ain    - operand A, sampled at acceptance
//   Bin    - operand B, sampled at acceptance
//   busy   - multiply in progress
//   done   - one-cycle completion pulse
//   AluOut - registered result
//   zero   - AluOut == 0
//   carry  - carry / borrow / multiply high half nonzero
//   ovf    - signed overflow (multiply: high half nonzero)
//   ill    - illegal opcode
module alu_seq #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       sl,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] AluOut,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             ill
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    logic [0:0]         r_state;
    logic               r_done, r_zero, r_carry, r_ovf, r_ill;
    logic [WIDTH-1:0]   r_out;
    logic [2*WIDTH-1:0] r_mcand, r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH:0]     w_sum, w_dif;
    logic [WIDTH-1:0]   w_res;
    logic               w_c, w_v, w_hi;
    logic [2*WIDTH-1:0] w_acc_nxt;

    always_comb begin
        w_sum = {1'b0, Ain} + {1'b0, Bin};
        w_dif = {1'b0, Ain} - {1'b0, Bin};
        w_res = sl == 3'b000 ? w_sum[WIDTH-1:0] :
                sl == 3'b001 ? w_dif[WIDTH-1:0] :
                sl == 3'b010 ? Ain & Bin :
                sl == 3'b011 ? ~Bin :
                sl == 3'b100 ? Ain | Bin :
                sl == 3'b101 ? Ain ^ Bin : '0;
        // top bit of the widened difference is the unsigned borrow
        w_c   = sl == 3'b000 ? w_sum[WIDTH] :
                sl == 3'b001 ? w_dif[WIDTH] : 1'b0;
        w_v   = sl == 3'b000 ? (Ain[WIDTH-1] == Bin[WIDTH-1]) && (w_sum[WIDTH-1] != Ain[WIDTH-1]) :
                sl == 3'b001 ? (Ain[WIDTH-1] != Bin[WIDTH-1]) && (w_dif[WIDTH-1] != Ain[WIDTH-1]) : 1'b0;
        // multiplicand is pre-shifted each step, so it always sits at the current bit position
        w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
        w_hi      = |w_acc_nxt[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_done   <= 1'b0;
            r_out    <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_ill    <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start && sl == 3'b110) begin
                    r_mcand  <= {{WIDTH{1'b0}}, Ain};
                    r_mplier <= Bin;
                    r_acc    <= '0;
                    r_cnt    <= CW'(WIDTH);
                    r_state  <= S_MUL;
                end else if (start) begin
                    r_out   <= w_res;
                    r_zero  <= w_res == '0;
                    r_carry <= w_c;
                    r_ovf   <= w_v;
                    r_ill   <= sl == 3'b111;
                    r_done  <= 1'b1;
                end
            end else begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_out   <= w_acc_nxt[WIDTH-1:0];
                    r_zero  <= w_acc_nxt[WIDTH-1:0] == '0;
                    r_carry <= w_hi;
                    r_ovf   <= w_hi;
                    r_ill   <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
            end
        end
    end

    assign busy   = r_state == S_MUL;
    assign done   = r_done;
    assign AluOut = r_out;
    assign zero   = r_zero;
    assign carry  = r_carry;
    assign ovf    = r_ovf;
    assign ill    = r_ill;
endmodule
